// File: rtl/ram_sdp_sync_pkg.sv
// Shared definitions for the decoder working-buffer RAMs: clear sequencer states,
// read-during-write mode codes and the legal read-latency range.
package ram_sdp_sync_pkg;

  typedef enum logic {
    CLR_ST_CLEAR = 1'b0,
    CLR_ST_RUN   = 1'b1
  } clr_state_e;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic bit rd_lat_legal(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

  function automatic bit rdw_mode_legal(input int mode);
    return (mode == RDW_READ_FIRST) || (mode == RDW_WRITE_FIRST);
  endfunction

endpackage

// File: rtl/ram_sdp_sync_clear_seq.sv
// Clear sequencer: walks the whole array once after reset or on request,
// owning the write port and holding off user traffic while it runs.
module ram_sdp_sync_clear_seq
  import ram_sdp_sync_pkg::*;
#(
  parameter int DEPTH  = 640,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLR_ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLR_ST_CLEAR: begin
        if (ptr_q == LAST_ADDR) begin
          state_d = CLR_ST_RUN;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_ONE;
        end
      end
      CLR_ST_RUN: begin
        if (clr_req) begin
          state_d = CLR_ST_CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = CLR_ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // busy drops combinationally with the state, i.e. right after the edge writing the last word
  assign busy     = (state_q == CLR_ST_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = ptr_q;

endmodule

// File: rtl/ram_sdp_sync.sv
// Simple-dual-port synchronous RAM with registered read (latency 1 or 2),
// read-during-write control, range checking and a built-in clear sequencer.
module ram_sdp_sync
  import ram_sdp_sync_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                DEPTH    = 640,
  parameter int                ADDR_W   = 10,
  parameter int                RD_LAT   = 1,
  parameter int                RDW_MODE = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              addr_err
);

  if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
    $error("ram_sdp_sync: RD_LAT must be 1 or 2");
  end
  if ((64'd1 << ADDR_W) < 64'(DEPTH)) begin : g_bad_depth
    $error("ram_sdp_sync: 2**ADDR_W must be >= DEPTH");
  end
  if (!rdw_mode_legal(RDW_MODE)) begin : g_bad_rdw
    $error("ram_sdp_sync: RDW_MODE must be 0 or 1");
  end

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic              seq_busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  ram_sdp_sync_clear_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .busy     (seq_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  logic wr_in_range, rd_in_range;
  logic wr_ok, wr_err, rd_acc, rd_err;

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_C);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_C);
  assign wr_ok       = wr_en & ~seq_busy & wr_in_range;
  assign wr_err      = wr_en & ~seq_busy & ~wr_in_range;
  assign rd_acc      = rd_en & ~seq_busy;
  assign rd_err      = rd_acc & ~rd_in_range;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // The sequencer owns the write port while clearing; user writes are dropped
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (seq_busy) begin
      mem_we    = clr_we;
      mem_waddr = clr_addr;
      mem_wdata = INIT_VAL;
    end else if (wr_ok) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  logic [DATA_W-1:0] rd_word;

  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[rd_addr];
      if ((RDW_MODE == RDW_WRITE_FIRST) && wr_ok && (wr_addr == rd_addr)) begin
        rd_word = wr_data;
      end
    end
  end

  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s1_err_q, s1_err_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              addr_err_q, addr_err_d;

  // With RD_LAT=2 a same-edge write error is folded into the later read error pulse
  always_comb begin
    s1_data_d  = s1_data_q;
    s1_valid_d = rd_acc;
    s1_err_d   = rd_err;
    if (rd_acc) begin
      s1_data_d = rd_word;
    end

    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    addr_err_d = 1'b0;
    if (RD_LAT == 1) begin
      rd_valid_d = rd_acc;
      addr_err_d = rd_err | wr_err;
      if (rd_acc) begin
        rd_data_d = rd_word;
      end
    end else begin
      rd_valid_d = s1_valid_q;
      addr_err_d = s1_err_q | (wr_err & ~rd_err);
      if (s1_valid_q) begin
        rd_data_d = s1_data_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      s1_data_q  <= s1_data_d;
      s1_valid_q <= s1_valid_d;
      s1_err_q   <= s1_err_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign busy     = seq_busy;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_ram_sdp_sync.sv
// Directed bench: two RAM instances share stimulus, one read-first with RD_LAT=1,
// one write-first with RD_LAT=2 and a non-zero clear value.
module tb_ram_sdp_sync;

  localparam logic [7:0] INIT1 = 8'h00;
  localparam logic [7:0] INIT2 = 8'h5A;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       clr_req = 1'b0;
  logic       wr_en   = 1'b0;
  logic       rd_en   = 1'b0;
  logic [9:0] wr_addr = '0;
  logic [9:0] rd_addr = '0;
  logic [7:0] wr_data = '0;

  logic       busy1, rd_valid1, addr_err1;
  logic [7:0] rd_data1;
  logic       busy2, rd_valid2, addr_err2;
  logic [7:0] rd_data2;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ram_sdp_sync #(
    .DATA_W(8), .DEPTH(640), .ADDR_W(10), .RD_LAT(1), .RDW_MODE(0), .INIT_VAL(INIT1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .addr_err(addr_err1)
  );

  ram_sdp_sync #(
    .DATA_W(8), .DEPTH(640), .ADDR_W(10), .RD_LAT(2), .RDW_MODE(1), .INIT_VAL(INIT2)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data2),
    .rd_valid(rd_valid2), .addr_err(addr_err2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until both instances leave busy; reports the step count and any stray output pulse
  task automatic count_busy(output int n1, output int n2, output bit spurious);
    n1 = 0;
    n2 = 0;
    spurious = 1'b0;
    for (int k = 1; k <= 3000; k++) begin
      step();
      if (rd_valid1 || addr_err1 || rd_valid2 || addr_err2) spurious = 1'b1;
      if (n1 == 0 && busy1 === 1'b0) n1 = k;
      if (n2 == 0 && busy2 === 1'b0) n2 = k;
      if (n1 != 0 && n2 != 0) break;
    end
  endtask

  task automatic test_reset();
    int n1, n2;
    bit sp;
    rst_n = 1'b0;
    #13;
    vectors++;
    if (busy1 !== 1'b1 || rd_valid1 !== 1'b0 || rd_data1 !== 8'h00 || addr_err1 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_dut1: busy=%b valid=%b data=%h err=%b, expected 1 0 00 0", busy1, rd_valid1, rd_data1, addr_err1);
    end
    vectors++;
    if (busy2 !== 1'b1 || rd_valid2 !== 1'b0 || rd_data2 !== 8'h00 || addr_err2 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_dut2: busy=%b valid=%b data=%h err=%b, expected 1 0 00 0", busy2, rd_valid2, rd_data2, addr_err2);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    rd_en   = 1'b1;
    rd_addr = 10'd700;
    wr_en   = 1'b1;
    wr_addr = 10'd3;
    wr_data = 8'hFF;
    clr_req = 1'b1;
    count_busy(n1, n2, sp);
    rd_en = 1'b0; wr_en = 1'b0; clr_req = 1'b0;
    vectors++;
    if (n1 != 640 || n2 != 640) begin
      miscompares++;
      $display("[TB] FAIL reset_busy_len: got %0d/%0d cycles, expected 640/640", n1, n2);
    end
    vectors++;
    if (sp) begin
      miscompares++;
      $display("[TB] FAIL reset_busy_blocks: got a valid/err pulse while busy, expected none");
    end
  endtask

  task automatic test_init_read();
    logic [9:0] addrs [2];
    addrs = '{10'd0, 10'd3};
    addrs[1] = 10'd639;
    for (int i = 0; i < 2; i++) begin
      rd_en = 1'b1; rd_addr = addrs[i];
      step();
      rd_en = 1'b0;
      vectors++;
      if (rd_valid1 !== 1'b1 || rd_data1 !== INIT1 || rd_valid2 !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL init_read_a%0d: dut1 v=%b d=%h dut2 v=%b, expected 1 %h 0", addrs[i], rd_valid1, rd_data1, rd_valid2, INIT1);
      end
      step();
      vectors++;
      if (rd_valid2 !== 1'b1 || rd_data2 !== INIT2 || rd_valid1 !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL init_read_b%0d: dut2 v=%b d=%h dut1 v=%b, expected 1 %h 0", addrs[i], rd_valid2, rd_data2, rd_valid1, INIT2);
      end
    end
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 10'd5; wr_data = 8'hA5;
    step();
    wr_en = 1'b0;
    rd_en = 1'b1; rd_addr = 10'd5;
    step();
    rd_en = 1'b0;
    vectors++;
    if (rd_valid1 !== 1'b1 || rd_data1 !== 8'hA5 || rd_valid2 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wr_rd_lat1: dut1 v=%b d=%h dut2 v=%b, expected 1 a5 0", rd_valid1, rd_data1, rd_valid2);
    end
    step();
    vectors++;
    if (rd_valid2 !== 1'b1 || rd_data2 !== 8'hA5 || rd_valid1 !== 1'b0 || rd_data1 !== 8'hA5) begin
      miscompares++;
      $display("[TB] FAIL wr_rd_lat2: dut2 v=%b d=%h dut1 v=%b d=%h, expected 1 a5 0 a5", rd_valid2, rd_data2, rd_valid1, rd_data1);
    end
    step();
    vectors++;
    if (rd_valid2 !== 1'b0 || rd_data2 !== 8'hA5) begin
      miscompares++;
      $display("[TB] FAIL wr_rd_hold: dut2 v=%b d=%h, expected 0 a5", rd_valid2, rd_data2);
    end
  endtask

  task automatic test_rdw();
    wr_en = 1'b1; wr_addr = 10'd7; wr_data = 8'h11;
    step();
    wr_data = 8'h3C;
    rd_en = 1'b1; rd_addr = 10'd7;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    vectors++;
    if (rd_valid1 !== 1'b1 || rd_data1 !== 8'h11) begin
      miscompares++;
      $display("[TB] FAIL rdw_read_first: v=%b d=%h, expected 1 11", rd_valid1, rd_data1);
    end
    step();
    vectors++;
    if (rd_valid2 !== 1'b1 || rd_data2 !== 8'h3C) begin
      miscompares++;
      $display("[TB] FAIL rdw_write_first: v=%b d=%h, expected 1 3c", rd_valid2, rd_data2);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    vectors++;
    if (rd_valid1 !== 1'b1 || rd_data1 !== 8'h3C) begin
      miscompares++;
      $display("[TB] FAIL rdw_after_dut1: v=%b d=%h, expected 1 3c", rd_valid1, rd_data1);
    end
    step();
    vectors++;
    if (rd_valid2 !== 1'b1 || rd_data2 !== 8'h3C) begin
      miscompares++;
      $display("[TB] FAIL rdw_after_dut2: v=%b d=%h, expected 1 3c", rd_valid2, rd_data2);
    end
  endtask

  task automatic test_out_of_range();
    rd_en = 1'b1; rd_addr = 10'd700;
    step();
    rd_en = 1'b0;
    vectors++;
    if (rd_valid1 !== 1'b1 || rd_data1 !== 8'h00 || addr_err1 !== 1'b1 || rd_valid2 !== 1'b0 || addr_err2 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL oor_read_a: dut1 v=%b d=%h e=%b dut2 v=%b e=%b, expected 1 00 1 0 0", rd_valid1, rd_data1, addr_err1, rd_valid2, addr_err2);
    end
    step();
    vectors++;
    if (rd_valid2 !== 1'b1 || rd_data2 !== 8'h00 || addr_err2 !== 1'b1 || rd_valid1 !== 1'b0 || addr_err1 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL oor_read_b: dut2 v=%b d=%h e=%b dut1 v=%b e=%b, expected 1 00 1 0 0", rd_valid2, rd_data2, addr_err2, rd_valid1, addr_err1);
    end
    wr_en = 1'b1; wr_addr = 10'd650; wr_data = 8'h77;
    step();
    wr_en = 1'b0;
    vectors++;
    if (addr_err1 !== 1'b1 || addr_err2 !== 1'b1 || rd_valid1 !== 1'b0 || rd_valid2 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL oor_write_err: e1=%b e2=%b v1=%b v2=%b, expected 1 1 0 0", addr_err1, addr_err2, rd_valid1, rd_valid2);
    end
    step();
    vectors++;
    if (addr_err1 !== 1'b0 || addr_err2 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL oor_write_pulse: e1=%b e2=%b, expected 0 0", addr_err1, addr_err2);
    end
    wr_en = 1'b1; wr_addr = 10'd650; rd_en = 1'b1; rd_addr = 10'd700;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    vectors++;
    if (addr_err1 !== 1'b1 || addr_err2 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL oor_both_a: e1=%b e2=%b, expected 1 0", addr_err1, addr_err2);
    end
    step();
    vectors++;
    if (addr_err1 !== 1'b0 || addr_err2 !== 1'b1 || rd_valid2 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL oor_both_b: e1=%b e2=%b v2=%b, expected 0 1 1", addr_err1, addr_err2, rd_valid2);
    end
    step();
    vectors++;
    if (addr_err1 !== 1'b0 || addr_err2 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL oor_both_c: e1=%b e2=%b, expected 0 0", addr_err1, addr_err2);
    end
  endtask

  task automatic test_stream();
    int cnt1, cnt2;
    logic [7:0] exp;
    cnt1 = 0;
    cnt2 = 0;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 10'(i); wr_data = 8'(8'h20 + i);
      step();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 18; i++) begin
      rd_en   = (i < 16);
      rd_addr = 10'(i);
      step();
      if (i < 16) begin
        exp = 8'(8'h20 + i);
        vectors++;
        if (rd_valid1 !== 1'b1 || rd_data1 !== exp) begin
          miscompares++;
          $display("[TB] FAIL stream_dut1_%0d: v=%b d=%h, expected 1 %h", i, rd_valid1, rd_data1, exp);
        end
      end
      if (i >= 1 && i < 17) begin
        exp = 8'(8'h20 + i - 1);
        vectors++;
        if (rd_valid2 !== 1'b1 || rd_data2 !== exp) begin
          miscompares++;
          $display("[TB] FAIL stream_dut2_%0d: v=%b d=%h, expected 1 %h", i, rd_valid2, rd_data2, exp);
        end
      end
      if (rd_valid1 === 1'b1) cnt1++;
      if (rd_valid2 === 1'b1) cnt2++;
    end
    rd_en = 1'b0;
    vectors++;
    if (cnt1 != 16 || cnt2 != 16) begin
      miscompares++;
      $display("[TB] FAIL stream_count: got %0d/%0d pulses, expected 16/16", cnt1, cnt2);
    end
  endtask

  task automatic test_clear_inflight();
    int n1, n2;
    bit sp;
    rd_en = 1'b1; rd_addr = 10'd5;
    step();
    vectors++;
    if (rd_valid1 !== 1'b1 || rd_data1 !== 8'h25 || busy1 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL clr_pre_read: v=%b d=%h busy=%b, expected 1 25 0", rd_valid1, rd_data1, busy1);
    end
    rd_addr = 10'd7; clr_req = 1'b1;
    step();
    rd_en = 1'b0; clr_req = 1'b0;
    vectors++;
    if (busy1 !== 1'b1 || busy2 !== 1'b1 || rd_valid1 !== 1'b1 || rd_data1 !== 8'h27 || rd_valid2 !== 1'b1 || rd_data2 !== 8'h25) begin
      miscompares++;
      $display("[TB] FAIL clr_inflight_a: b=%b%b dut1 v=%b d=%h dut2 v=%b d=%h, expected 11 1 27 1 25", busy1, busy2, rd_valid1, rd_data1, rd_valid2, rd_data2);
    end
    step();
    vectors++;
    if (rd_valid1 !== 1'b0 || rd_valid2 !== 1'b1 || rd_data2 !== 8'h27) begin
      miscompares++;
      $display("[TB] FAIL clr_inflight_b: dut1 v=%b dut2 v=%b d=%h, expected 0 1 27", rd_valid1, rd_valid2, rd_data2);
    end
    rd_en = 1'b1; rd_addr = 10'd5; clr_req = 1'b1;
    count_busy(n1, n2, sp);
    rd_en = 1'b0; clr_req = 1'b0;
    vectors++;
    if (n1 != 639 || n2 != 639 || sp) begin
      miscompares++;
      $display("[TB] FAIL clr_busy: got %0d/%0d more cycles stray=%b, expected 639/639 0", n1, n2, sp);
    end
    rd_en = 1'b1; rd_addr = 10'd5;
    step();
    rd_en = 1'b0;
    step();
    vectors++;
    if (rd_data1 !== INIT1 || rd_valid2 !== 1'b1 || rd_data2 !== INIT2) begin
      miscompares++;
      $display("[TB] FAIL clr_result: d1=%h v2=%b d2=%h, expected %h 1 %h", rd_data1, rd_valid2, rd_data2, INIT1, INIT2);
    end
  endtask

  task automatic test_reset_mid();
    int n1, n2;
    bit sp;
    wr_en = 1'b1; wr_addr = 10'd639; wr_data = 8'h99;
    step();
    wr_en = 1'b0;
    rd_en = 1'b1; rd_addr = 10'd639;
    step();
    rd_en = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (rd_valid1 !== 1'b0 || rd_data1 !== 8'h00 || busy1 !== 1'b1 || busy2 !== 1'b1 || rd_data2 !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_read: v1=%b d1=%h b=%b%b d2=%h, expected 0 00 11 00", rd_valid1, rd_data1, busy1, busy2, rd_data2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    count_busy(n1, n2, sp);
    vectors++;
    if (n1 != 640 || n2 != 640 || sp) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_read_clear: got %0d/%0d stray=%b, expected 640/640 0", n1, n2, sp);
    end
    wr_en = 1'b1; wr_addr = 10'd639; wr_data = 8'h99;
    step();
    wr_en = 1'b0;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    step();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (100) step();
    vectors++;
    if (rd_data1 !== 8'h99 || rd_data2 !== 8'h99 || busy1 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_clear_pre: d1=%h d2=%h busy=%b, expected 99 99 1", rd_data1, rd_data2, busy1);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (rd_data1 !== 8'h00 || rd_data2 !== 8'h00 || busy1 !== 1'b1 || busy2 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_clear: d1=%h d2=%h b=%b%b, expected 00 00 11", rd_data1, rd_data2, busy1, busy2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    count_busy(n1, n2, sp);
    vectors++;
    if (n1 != 640 || n2 != 640 || sp) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_clear_len: got %0d/%0d stray=%b, expected 640/640 0", n1, n2, sp);
    end
    rd_en = 1'b1; rd_addr = 10'd639;
    step();
    rd_en = 1'b0;
    step();
    vectors++;
    if (rd_data1 !== INIT1 || rd_valid2 !== 1'b1 || rd_data2 !== INIT2) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_clear_data: d1=%h v2=%b d2=%h, expected %h 1 %h", rd_data1, rd_valid2, rd_data2, INIT1, INIT2);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_init_read();
    test_write_read();
    test_rdw();
    test_out_of_range();
    test_stream();
    test_clear_inflight();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
